// File: rtl/cmd_saver.sv
// cmd_saver: reads a CPU memory range and emits it as a TRS-80 /CMD byte
// stream (type-01 load records followed by one type-02 transfer record)
// on the ioctl upload data path.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   start             one-cycle pulse that begins a save (ignored while busy)
//   start_addr        first address to save (latched on start)
//   end_addr          last address to save, inclusive (latched on start)
//   exec_addr         transfer/entry address (latched on start)
//   mem_addr, mem_rd  RAM read address and one-cycle read strobe
//   mem_data          RAM read data, valid MEM_LATENCY cycles after mem_rd
//   out_wr            one-cycle write strobe for out_data at out_addr
//   out_addr          byte offset in the output file
//   out_data          output byte
//   out_wait          backpressure; no out_wr is issued while high
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle completion pulse
//   err               sticky range error (end_addr < start_addr)
//   file_size         total bytes emitted, valid at done, held until next start
module cmd_saver #(
  parameter int BLOCK_SIZE  = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] exec_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        out_wr,
  output logic [16:0] out_addr,
  output logic [7:0]  out_data,
  input  logic        out_wait,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [16:0] file_size
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_H_TYPE,
    S_H_LEN,
    S_H_ALO,
    S_H_AHI,
    S_RD_REQ,
    S_RD_WAIT,
    S_D_OUT,
    S_X_TYPE,
    S_X_LEN,
    S_X_LO,
    S_X_HI,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] cur_addr;   // next RAM address; equals block address during a header
  logic [15:0] exec_lat;
  logic [16:0] remaining;  // range bytes not yet emitted (17 bits: full 64K range)
  logic [8:0]  blk_left;   // data bytes not yet emitted in the current block
  logic [16:0] wr_ptr;
  logic [7:0]  data_byte;
  logic [2:0]  lat_cnt;

  logic [8:0]  blk_n;
  logic        emit;
  logic [7:0]  emit_byte;

  // Size of the block about to start; remaining is stable during the header.
  always_comb begin
    blk_n = (remaining > 17'(BLOCK_SIZE)) ? 9'(BLOCK_SIZE) : remaining[8:0];
  end

  always_comb begin
    emit      = 1'b1;
    emit_byte = '0;
    unique case (state)
      S_H_TYPE: emit_byte = 8'h01;
      S_H_LEN:  emit_byte = blk_n[7:0] + 8'd2;  // (N+2) mod 256
      S_H_ALO:  emit_byte = cur_addr[7:0];
      S_H_AHI:  emit_byte = cur_addr[15:8];
      S_D_OUT:  emit_byte = data_byte;
      S_X_TYPE: emit_byte = 8'h02;
      S_X_LEN:  emit_byte = 8'h02;
      S_X_LO:   emit_byte = exec_lat[7:0];
      S_X_HI:   emit_byte = exec_lat[15:8];
      default:  emit      = 1'b0;
    endcase
  end

  // out_wr is gated by out_wait in the same cycle so a write is never
  // issued while backpressure is asserted; out_data/out_addr come straight
  // from registers and therefore hold steady while waiting.
  assign out_wr   = emit & ~out_wait;
  assign out_data = emit ? emit_byte : '0;
  assign out_addr = wr_ptr;
  assign mem_addr = cur_addr;
  assign mem_rd   = (state == S_RD_REQ);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      exec_lat  <= '0;
      remaining <= '0;
      blk_left  <= '0;
      wr_ptr    <= '0;
      data_byte <= '0;
      lat_cnt   <= '0;
      err       <= 1'b0;
      file_size <= '0;
    end else begin
      if (out_wr) wr_ptr <= wr_ptr + 17'd1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            exec_lat  <= exec_addr;
            wr_ptr    <= '0;
            file_size <= '0;
            remaining <= {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
            if (end_addr < start_addr) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              state <= S_H_TYPE;
            end
          end
        end
        S_H_TYPE: if (!out_wait) begin
          blk_left <= blk_n;
          state    <= S_H_LEN;
        end
        S_H_LEN:  if (!out_wait) state <= S_H_ALO;
        S_H_ALO:  if (!out_wait) state <= S_H_AHI;
        S_H_AHI:  if (!out_wait) state <= S_RD_REQ;
        S_RD_REQ: begin
          lat_cnt <= '0;
          state   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (lat_cnt == 3'(MEM_LATENCY - 1)) begin
            data_byte <= mem_data;
            state     <= S_D_OUT;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_D_OUT: if (!out_wait) begin
          // cur_addr may wrap past FFFF here, but remaining reaches zero at
          // the same time so no further block is started from 0000.
          cur_addr  <= cur_addr + 16'd1;
          remaining <= remaining - 17'd1;
          blk_left  <= blk_left - 9'd1;
          if (blk_left != 9'd1)       state <= S_RD_REQ;
          else if (remaining != 17'd1) state <= S_H_TYPE;
          else                         state <= S_X_TYPE;
        end
        S_X_TYPE: if (!out_wait) state <= S_X_LEN;
        S_X_LEN:  if (!out_wait) state <= S_X_LO;
        S_X_LO:   if (!out_wait) state <= S_X_HI;
        S_X_HI: if (!out_wait) begin
          file_size <= wr_ptr + 17'd1;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_saver.sv
// Self-checking bench for cmd_saver: directed save jobs against a RAM model
// with MEM_LATENCY pipeline, hand-computed expected streams and sizes.
module tb_cmd_saver;
  localparam int MEM_LAT = 2;
  localparam int BLK     = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0, end_addr = '0, exec_addr = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        out_wr;
  logic [16:0] out_addr;
  logic [7:0]  out_data;
  logic        out_wait = 1'b0;
  logic        busy, done, err;
  logic [16:0] file_size;

  cmd_saver #(.BLOCK_SIZE(BLK), .MEM_LATENCY(MEM_LAT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_wr(out_wr), .out_addr(out_addr), .out_data(out_data),
    .out_wait(out_wait), .busy(busy), .done(done), .err(err),
    .file_size(file_size)
  );

  always #5 clock = ~clock;

  // RAM model: data appears MEM_LAT cycles after the read strobe, and a
  // filler value otherwise so mistimed captures show up.
  logic [7:0] ram [0:65535];
  logic [7:0] pipe [0:MEM_LAT-1];
  always @(posedge clock) begin
    pipe[0] <= mem_rd ? ram[mem_addr] : 8'hEE;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data = pipe[MEM_LAT-1];

  // Output monitor
  logic [7:0] cap [0:4095];
  int cap_total = 0, run_base = 0, done_total = 0, rd_total = 0;
  int addr_err = 0, wait_viol = 0, stable_err = 0, rd_overlap = 0, since_rd = 100;
  logic        prev_wait = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;

  always @(negedge clock) begin
    if (out_wr) begin
      if (out_wait) wait_viol++;
      if (out_addr != 17'(cap_total - run_base)) addr_err++;
      cap[cap_total % 4096] = out_data;
      cap_total++;
    end
    if (prev_wait && out_addr == prev_addr && prev_data != 8'h00 && out_data != prev_data)
      stable_err++;
    prev_wait = out_wait;
    prev_addr = out_addr;
    prev_data = out_data;
    if (done) done_total++;
    if (mem_rd) begin
      if (since_rd <= MEM_LAT) rd_overlap++;
      rd_total++;
      since_rd = 0;
    end else if (since_rd < 100) begin
      since_rd++;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] capb(input int k);
    return cap[(run_base + k) % 4096];
  endfunction

  function automatic logic [63:0] all_outs();
    return {out_wr, mem_rd, busy, done, err, file_size, out_addr, out_data, mem_addr};
  endfunction

  int done_base, rd_base;

  task automatic run_save(input logic [15:0] s, input logic [15:0] e,
                          input logic [15:0] x, input bit rnd);
    int cyc;
    run_base  = cap_total;
    done_base = done_total;
    rd_base   = rd_total;
    @(posedge clock); #1;
    start = 1'b1; start_addr = s; end_addr = e; exec_addr = x;
    @(posedge clock); #1;
    start = 1'b0;
    out_wait = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    cyc = 0;
    while (done_total == done_base && cyc < 20000) begin
      @(posedge clock); #1;
      out_wait = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc++;
    end
    out_wait = 1'b0;
    check("done_timeout", 64'(cyc < 20000), 64'd1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  logic [7:0] exp1 [0:10];

  task automatic check_case1(input string tag);
    check({tag, "_len"}, 64'(cap_total - run_base), 64'd11);
    for (int i = 0; i < 11; i++) check({tag, "_byte"}, 64'(capb(i)), 64'(exp1[i]));
    check({tag, "_fsize"}, 64'(file_size), 64'd11);
    check({tag, "_done1"}, 64'(done_total - done_base), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic check_data(input string tag, input int off, input logic [15:0] a, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (capb(off + i) !== ram[16'(int'(a) + i)]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    exp1 = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC,
             8'h02, 8'h02, 8'h00, 8'h52};
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    ram[16'h5200] = 8'hAA; ram[16'h5201] = 8'hBB; ram[16'h5202] = 8'hCC;

    // Reset, with a start held during reset that must be ignored
    repeat (3) @(posedge clock);
    #1; start = 1'b1; start_addr = 16'h5200; end_addr = 16'h5202;
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    check("reset_outs", all_outs(), 64'd0);
    @(posedge clock); #1;
    check("start_in_reset_ignored", 64'(busy), 64'd0);

    // Basic three-byte save
    run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);
    check_case1("c1");

    // 257 bytes: split into 256 + 1
    run_save(16'h6000, 16'h6100, 16'h6000, 1'b0);
    check("c2_len", 64'(cap_total - run_base), 64'd269);
    check("c2_fsize", 64'(file_size), 64'd269);
    check("c2_hdr1", 64'({capb(0), capb(1), capb(2), capb(3)}), 64'h01020060);
    check_data("c2_data1", 4, 16'h6000, 256);
    check("c2_hdr2", 64'({capb(260), capb(261), capb(262), capb(263)}), 64'h01030061);
    check_data("c2_data2", 264, 16'h6100, 1);
    check("c2_xfer", 64'({capb(265), capb(266), capb(267), capb(268)}), 64'h02020060);

    // Range ending at FFFF
    run_save(16'hFF00, 16'hFFFF, 16'h1234, 1'b0);
    check("c3_len", 64'(cap_total - run_base), 64'd264);
    check("c3_fsize", 64'(file_size), 64'd264);
    check("c3_hdr", 64'({capb(0), capb(1), capb(2), capb(3)}), 64'h010200FF);
    check_data("c3_data", 4, 16'hFF00, 256);
    check("c3_xfer", 64'({capb(260), capb(261), capb(262), capb(263)}), 64'h02023412);
    check("c3_reads", 64'(rd_total - rd_base), 64'd256);

    // Random backpressure on the basic case
    run_save(16'h5200, 16'h5202, 16'h5200, 1'b1);
    check_case1("c4");
    check("c4_stable", 64'(stable_err), 64'd0);

    // Inverted range
    run_save(16'h7000, 16'h6FFF, 16'h7000, 1'b0);
    check("c5_nowr", 64'(cap_total - run_base), 64'd0);
    check("c5_done1", 64'(done_total - done_base), 64'd1);
    check("c5_err", 64'(err), 64'd1);
    check("c5_fsize", 64'(file_size), 64'd0);
    run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);
    check_case1("c5b");

    // Reset during RD_WAIT
    begin
      int cyc = 0;
      int wr_at_rst;
      run_base  = cap_total;
      done_base = done_total;
      @(posedge clock); #1;
      start = 1'b1; start_addr = 16'h5200; end_addr = 16'h5202; exec_addr = 16'h5200;
      @(posedge clock); #1;
      start = 1'b0;
      while (!mem_rd && cyc < 100) begin
        @(negedge clock);
        cyc++;
      end
      check("c6_rd_seen", 64'(mem_rd), 64'd1);
      @(posedge clock); #1;           // now in RD_WAIT
      reset = 1'b1;
      @(posedge clock); #1;
      check("c6_reset_outs", all_outs(), 64'd0);
      wr_at_rst = cap_total;
      reset = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("c6_no_done", 64'(done_total - done_base), 64'd0);
      check("c6_no_wr", 64'(cap_total - wr_at_rst), 64'd0);
    end
    run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);
    check_case1("c6b");

    check("addr_seq", 64'(addr_err), 64'd0);
    check("wr_while_wait", 64'(wait_viol), 64'd0);
    check("rd_overlap", 64'(rd_overlap), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_saver.md
Name: cmd_saver

Overview:
- Encoder counterpart of cmd_loader. Reads a CPU memory range and emits it as a TRS-80 /CMD byte stream for upload to the HPS.
- Output stream format: one or more type-01 load records, then one type-02 transfer record.
- Sits beside cmd_loader in the emu top level. Reads TRS-80 RAM through a spare read port and drives the ioctl upload data path.

Parameters:
- BLOCK_SIZE, 256: maximum data bytes per load record. Legal range 1..256.
- MEM_LATENCY, 2: cycles from mem_rd to a valid mem_data. Legal range 1..4.

Ports:
- clock  in  1  system clock (clk_sys, 42 MHz).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a save. Ignored while busy.
- start_addr  in  16  first address to save. Latched on start.
- end_addr  in  16  last address to save, inclusive. Latched on start.
- exec_addr  in  16  transfer (entry) address. Latched on start.
- mem_addr  out  16  RAM read address.
- mem_rd  out  1  one-cycle read strobe.
- mem_data  in  8  RAM read data, valid MEM_LATENCY cycles after mem_rd.
- out_wr  out  1  one-cycle strobe; out_data is valid at out_addr.
- out_addr  out  17  byte offset in the output file.
- out_data  out  8  output byte.
- out_wait  in  1  backpressure. While high, no out_wr may be issued.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky. Set if end_addr < start_addr; cleared by the next accepted start.
- file_size  out  17  total bytes emitted. Valid when done pulses; held until the next start.

Behaviour:
- Reset values: every output is 0, and the state is IDLE. Reset mid-operation aborts immediately, emits no further out_wr, does not pulse done, and discards latched values.
- Record formats:
  - Load record: 0x01, LEN, ADDR_LO, ADDR_HI, then N data bytes. LEN = (N+2) mod 256, so N=254 gives 0x00, N=255 gives 0x01, N=256 gives 0x02.
  - Transfer record: 0x02, 0x02, EXEC_LO, EXEC_HI.
- Block splitting: N = min(BLOCK_SIZE, remaining). remaining is held in 17 bits, so a full range 0000-FFFF yields 65536 bytes.
- Address arithmetic: each block address is the previous block address + previous N.
- States:
  - IDLE: on start, latch the inputs. If end_addr < start_addr, go to DONE with err=1 and file_size=0, emitting nothing. Otherwise go to H_TYPE.
  - H_TYPE, H_LEN, H_ALO, H_AHI: emit one header byte each.
  - RD_REQ: pulse mem_rd with mem_addr = current address.
  - RD_WAIT: count MEM_LATENCY cycles, then capture mem_data.
  - D_OUT: emit the captured byte. If bytes remain in the block, go to RD_REQ. Else if range bytes remain, go to H_TYPE. Else go to X_TYPE.
  - X_TYPE, X_LEN, X_LO, X_HI: emit the transfer record. X_HI goes to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- Emit states: an emit state drives out_wr=1 for exactly one cycle when out_wait=0. If out_wait=1, the block stays in the state with out_wr=0 and out_data/out_addr held stable. After each write, out_addr increments.
- mem_rd is never issued while a previous read is outstanding.
- The address counter must not wrap into the next block incorrectly at FFFF. The range ends at FFFF without overflow of remaining.
- start during busy is ignored. A start coincident with reset is ignored.
- Throughput: at most one out_wr per cycle. With out_wait=0, a data byte costs MEM_LATENCY+2 cycles (RD_REQ, MEM_LATENCY RD_WAIT cycles, D_OUT).
- file_size = 4·(number of blocks) + data bytes + 4.

Test Plan:
- start=0x5200, end=0x5202, exec=0x5200, RAM = AA BB CC. Stream must be 01 05 00 52 AA BB CC 02 02 00 52 at out_addr 0..10. file_size=11, done pulses once, err=0.
- start=0x6000, end=0x6100 (257 bytes), BLOCK_SIZE=256. First header 01 02 00 60 followed by 256 bytes. Second block 01 03 00 61 followed by 1 byte. Then the transfer record. file_size=269.
- start=0xFF00, end=0xFFFF: a single block 01 02 00 FF with 256 bytes. No wrap to 0000. file_size=264.
- Random out_wait toggling (≈50% duty) on the first case: an identical byte sequence with no duplicated or dropped out_addr, and out_data stable throughout every wait.
- start=0x7000, end=0x6FFF: no out_wr, done pulses, err=1, file_size=0. A subsequent valid start clears err.
- Reset asserted mid-block during RD_WAIT: all outputs 0 next cycle, no done. A new start then produces a correct, complete stream from out_addr 0.
